gaussian_row_sequencer: RTL and testbench
=========================================

# gaussian_row_sequencer

Controller that drives the 10-row line buffer through one Gaussian pass. On `start` it streams `ROWS` image rows out of the image SRAM and drives the buffer's `buffer_mode` / `buffer_we` so that each row reaches `buffer_data_0` aligned with its SRAM read. It then flushes the pipeline and tags the cycles in which the buffer's center tap holds a real row, so the downstream Gaussian filter knows when to consume. It sits between the system FSM and the line buffer, and owns the SRAM read port during `SYS_GAUSSIAN`.

## Interface
Parameters:
- `ROWS`, 480: image rows per pass.
- `RD_LAT`, 1: SRAM read latency in cycles; must be ≥1.
- `CENTER`, 2: buffer tap index treated as the filter center row (0..9).
- `ADDR_W`, 16: SRAM address width.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin a pass; sampled only in IDLE.
- `abort`, in, 1: cancel the pass immediately.
- `base_addr`, in, `ADDR_W`: SRAM address of row 0; latched on accepted `start`.
- `sram_re`, out, 1: SRAM row read enable.
- `sram_addr`, out, `ADDR_W`: SRAM row address.
- `buffer_mode`, out, 3: to line buffer; `SYS_GAUSSIAN`=1 while active, `SYS_IDLE`=0 otherwise.
- `buffer_we`, out, 1: to line buffer; high in the cycle SRAM data for a row is on `img_data`.
- `win_valid`, out, 1: buffer tap `CENTER` holds a real image row this cycle.
- `win_row`, out, `$clog2(ROWS)`: index of the row in tap `CENTER`; 0 when `win_valid`=0.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse at the end of a completed pass.

## Operation
- States are IDLE, READ, FLUSH and DONE.
- **IDLE:** all outputs 0. When `start`=1 (and `abort`=0):
  - latch `base_addr`, clear the row counter;
  - go to READ.
- **READ:** lasts exactly `ROWS` cycles; cycle i = 0..`ROWS`-1.
  - Drive `sram_re`=1, `sram_addr`=base+i, `buffer_mode`=1.
  - After i=`ROWS`-1, go to FLUSH.
- **FLUSH:** lasts exactly F = `RD_LAT`+1+`CENTER` cycles.
  - Drive `sram_re`=0, `buffer_mode`=1.
  - The line buffer keeps shifting; it shifts zeros in because `buffer_we`=0.
  - Then go to DONE.
- **DONE:** one cycle with `done`=1, `buffer_mode`=0, `busy`=1; then go to IDLE.
  - With `buffer_mode`=0 the line buffer returns to its idle state and clears itself.
- **`buffer_we`:** `sram_re` delayed by `RD_LAT` cycles (shift register).
- **`win_valid`:** `sram_re` delayed by `RD_LAT`+1+`CENTER` cycles.
- **`win_row`:** the row counter delayed alongside `win_valid`, through the same pipeline.
- **Abort:** `abort`=1 in any state other than IDLE:
  - next cycle is IDLE;
  - all delay pipelines are cleared;
  - no `done` pulse;
  - `buffer_mode`=0 next cycle.
- **Simultaneous `start` and `abort` in IDLE:** `abort` wins, and the block stays in IDLE.
- **`start` while busy:** ignored.
- **Row counter:** counts 0..`ROWS`-1 with no wrap. `sram_addr` is computed modulo 2^`ADDR_W` (wraps silently).
- **Reset, including mid-pass:**
  - every output goes to 0 and the state goes to IDLE;
  - pipelines are cleared;
  - the latched base is cleared to 0.

## Timing
- All outputs are registered.
- **Start latency:** `start` sampled at edge of cycle s; READ cycle 0 is cycle s+1, with `buffer_mode`=1 already set.
- **Line buffer entry:** the buffer enters its Gaussian state at s+2. This is no later than the first `buffer_we` (s+1+`RD_LAT`), hence the `RD_LAT`≥1 requirement.
- **Row i position:** row i is in `buffer_data_0` in cycle s+2+i+`RD_LAT`, and in tap `CENTER` in cycle s+2+i+`RD_LAT`+`CENTER`.
- **Final window:** the last `win_valid` lands in the final FLUSH cycle.
- **Pass length:** total busy length is `ROWS`+F+1 cycles.
- **Throughput:** `win_valid` is high for exactly `ROWS` consecutive cycles per pass.

## Structure
- **Shared package `sift_pkg`:**
  - system-mode constants `SYS_IDLE`=0, `SYS_GAUSSIAN`=1, `SYS_DETECT_KP`=2, `SYS_FILTER_KP`=3, `SYS_MATCH`=4;
  - the sequencer state enum.
- **Sub-module `valid_delay`:** parameterized depth N, width W, synchronous clear. Instantiated three times:
  - `re`→`we`, depth `RD_LAT`;
  - `re`→`win_valid`, depth `RD_LAT`+1+`CENTER`;
  - row index → `win_row`, same depth as `win_valid`.

## Test plan
All scenarios use `ROWS`=4, `RD_LAT`=1, `CENTER`=2 unless stated.
- **Nominal pass:** `start` at cycle 0, `base_addr`=0x100 ->
  - `sram_re` in cycles 1–4 with addresses 0x100..0x103;
  - `buffer_we` in cycles 2–5;
  - `win_valid` in cycles 5–8 with `win_row` 0,1,2,3;
  - `buffer_mode`=1 in cycles 1–8;
  - `done` in cycle 9;
  - `busy` in cycles 1–9.
- **With line-buffer model attached:** tap 2 contents equal SRAM rows 0..3 exactly in cycles 5..8, and zero after cycle 9.
- **Abort:** `abort` at cycle 3 -> IDLE in cycle 4, all outputs 0, no `done`, no further `win_valid`.
- **Reset mid-pass:** `rst_n`=0 at cycle 6 -> all outputs 0 in cycle 7. A following `start` runs a clean pass.
- **Start handling:**
  - `start` held high through a whole pass -> a second pass begins the cycle after DONE;
  - `start` pulses during busy -> ignored.
- **Longer read latency:** `RD_LAT`=3 -> `buffer_we` in cycles 4–7, `win_valid` in cycles 7–10, `done` in cycle 11.

Source files
------------

// File: rtl/sift_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sift_pkg: system-mode codes and shared state enums for the SIFT pipeline  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
package sift_pkg;

    localparam logic [2:0] SYS_IDLE      = 3'd0;
    localparam logic [2:0] SYS_GAUSSIAN  = 3'd1;
    localparam logic [2:0] SYS_DETECT_KP = 3'd2;
    localparam logic [2:0] SYS_FILTER_KP = 3'd3;
    localparam logic [2:0] SYS_MATCH     = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/valid_delay.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | valid_delay: N-stage, W-bit register delay line with synchronous clear    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module valid_delay #(
    parameter int N = 1,
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [N];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < N; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < N; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[N-1];

endmodule
`default_nettype wire

// File: rtl/gaussian_row_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | gaussian_row_sequencer: streams image rows from SRAM into the line buffer |
// | for one Gaussian pass and tags valid center-tap windows. Revision: 1.0    |
// +---------------------------------------------------------------------------+
module gaussian_row_sequencer
    import sift_pkg::*;
#(
    parameter int ROWS   = 480,
    parameter int RD_LAT = 1,
    parameter int CENTER = 2,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic                     sram_re,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [2:0]               buffer_mode,
    output logic                     buffer_we,
    output logic                     win_valid,
    output logic [$clog2(ROWS)-1:0]  win_row,
    output logic                     busy,
    output logic                     done
);

    localparam int ROW_W     = $clog2(ROWS);
    localparam int FLUSH_LEN = RD_LAT + 1 + CENTER;
    localparam int FC_W      = $clog2(FLUSH_LEN + 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [FC_W-1:0]  LAST_FLUSH = FC_W'(FLUSH_LEN - 1);

    seq_state_t        state;
    logic [ADDR_W-1:0] base;
    logic [ROW_W-1:0]  row;
    logic [FC_W-1:0]   flush_cnt;
    logic              pipe_clear;
    logic [ROW_W-1:0]  row_tap;

    assign pipe_clear = !rst_n || (abort && state != ST_IDLE);
    // Gate the index so win_row reads 0 whenever win_valid is low.
    assign row_tap    = sram_re ? row : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            base        <= '0;
            row         <= '0;
            flush_cnt   <= '0;
            sram_re     <= 1'b0;
            sram_addr   <= '0;
            buffer_mode <= SYS_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort && state != ST_IDLE) begin
            state       <= ST_IDLE;
            row         <= '0;
            flush_cnt   <= '0;
            sram_re     <= 1'b0;
            sram_addr   <= '0;
            buffer_mode <= SYS_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state       <= ST_READ;
                        base        <= base_addr;
                        row         <= '0;
                        sram_re     <= 1'b1;
                        sram_addr   <= base_addr;
                        buffer_mode <= SYS_GAUSSIAN;
                        busy        <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (row == LAST_ROW) begin
                        state     <= ST_FLUSH;
                        sram_re   <= 1'b0;
                        sram_addr <= '0;
                        flush_cnt <= '0;
                    end else begin
                        row       <= row + ROW_W'(1);
                        sram_addr <= base + ADDR_W'(row) + ADDR_W'(1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state       <= ST_DONE;
                        buffer_mode <= SYS_IDLE;
                        done        <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    valid_delay #(.N(RD_LAT), .W(1)) u_we_delay (
        .clk   (clk),
        .clear (pipe_clear),
        .din   (sram_re),
        .dout  (buffer_we)
    );

    valid_delay #(.N(FLUSH_LEN), .W(1)) u_win_delay (
        .clk   (clk),
        .clear (pipe_clear),
        .din   (sram_re),
        .dout  (win_valid)
    );

    valid_delay #(.N(FLUSH_LEN), .W(ROW_W)) u_row_delay (
        .clk   (clk),
        .clear (pipe_clear),
        .din   (row_tap),
        .dout  (win_row)
    );

endmodule
`default_nettype wire

// File: tb/tb_gaussian_row_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_gaussian_row_sequencer: table vectors, corner sequences and random     |
// | stimulus against a cycle-offset reference model. Revision: 1.0            |
// +---------------------------------------------------------------------------+
module tb_gaussian_row_sequencer;

    localparam int R = 4;
    localparam int C = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] base_addr = 16'h0;

    logic        a_re, a_we, a_wv, a_busy, a_done;
    logic [15:0] a_addr;
    logic [2:0]  a_mode;
    logic [1:0]  a_row;
    logic        b_re, b_we, b_wv, b_busy, b_done;
    logic [15:0] b_addr;
    logic [2:0]  b_mode;
    logic [1:0]  b_row;

    always #5 clk = ~clk;

    gaussian_row_sequencer #(.ROWS(R), .RD_LAT(1), .CENTER(C), .ADDR_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .sram_re(a_re), .sram_addr(a_addr), .buffer_mode(a_mode), .buffer_we(a_we),
        .win_valid(a_wv), .win_row(a_row), .busy(a_busy), .done(a_done)
    );

    gaussian_row_sequencer #(.ROWS(R), .RD_LAT(3), .CENTER(C), .ADDR_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .sram_re(b_re), .sram_addr(b_addr), .buffer_mode(b_mode), .buffer_we(b_we),
        .win_valid(b_wv), .win_row(b_row), .busy(b_busy), .done(b_done)
    );

    typedef struct packed {
        logic        re;
        logic [15:0] addr;
        logic        we;
        logic        wv;
        logic [1:0]  row;
        logic [2:0]  mode;
        logic        busy;
        logic        done;
    } exp_t;

    typedef struct {
        logic        st;
        logic [15:0] base;
        exp_t        e;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: k = cycle offset within the current pass (0 = idle).
    int          ka = 0, kb = 0;
    logic [15:0] mba = 16'h0, mbb = 16'h0;
    logic [31:0] tap [10];
    logic [31:0] img = 32'h0;

    function automatic logic [31:0] rowdata(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    function automatic exp_t mk(input logic re, input logic [15:0] addr, input logic we,
                                input logic wv, input logic [1:0] row, input logic [2:0] mode,
                                input logic busy, input logic done);
        exp_t e;
        e.re = re; e.addr = addr; e.we = we; e.wv = wv;
        e.row = row; e.mode = mode; e.busy = busy; e.done = done;
        return e;
    endfunction

    function automatic exp_t model_out(input int k, input int lat, input logic [15:0] mb);
        exp_t e;
        int   f;
        f      = lat + 1 + C;
        e.re   = (k >= 1 && k <= R);
        e.addr = e.re ? mb + 16'(k - 1) : 16'h0;
        e.we   = (k >= 1 + lat && k <= R + lat);
        e.wv   = (k >= lat + 2 + C && k <= R + f);
        e.row  = e.wv ? 2'(k - (lat + 2 + C)) : 2'd0;
        e.mode = (k >= 1 && k <= R + f) ? 3'd1 : 3'd0;
        e.busy = (k >= 1 && k <= R + f + 1);
        e.done = (k == R + f + 1);
        return e;
    endfunction

    task automatic adv(input int lat, inout int k, inout logic [15:0] mb);
        int f;
        f = lat + 1 + C;
        if (!rst_n) begin
            k  = 0;
            mb = 16'h0;
        end else if (k != 0) begin
            if (abort || k == R + f + 1) k = 0;
            else k++;
        end else if (start && !abort) begin
            k  = 1;
            mb = base_addr;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string p, input exp_t e, input logic re, input logic [15:0] addr,
                           input logic we, input logic wv, input logic [1:0] row,
                           input logic [2:0] mode, input logic busy, input logic done);
        chk({p, ".re"},   32'(re),   32'(e.re));
        chk({p, ".addr"}, 32'(addr), 32'(e.addr));
        chk({p, ".we"},   32'(we),   32'(e.we));
        chk({p, ".wv"},   32'(wv),   32'(e.wv));
        chk({p, ".row"},  32'(row),  32'(e.row));
        chk({p, ".mode"}, 32'(mode), 32'(e.mode));
        chk({p, ".busy"}, 32'(busy), 32'(e.busy));
        chk({p, ".done"}, 32'(done), 32'(e.done));
    endtask

    task automatic step();
        logic        pre_re, pre_we;
        logic [15:0] pre_addr;
        logic [2:0]  pre_mode;
        exp_t        ea, eb;
        pre_re = a_re; pre_we = a_we; pre_addr = a_addr; pre_mode = a_mode;
        @(posedge clk);
        adv(1, ka, mba);
        adv(3, kb, mbb);
        // Line-buffer + SRAM environment around DUT A.
        if (pre_mode !== 3'd1) begin
            for (int i = 0; i < 10; i++) tap[i] = 32'h0;
        end else begin
            for (int i = 9; i > 0; i--) tap[i] = tap[i-1];
            tap[0] = (pre_we === 1'b1) ? img : 32'h0;
        end
        img = (pre_re === 1'b1) ? rowdata(pre_addr) : 32'h0;
        #1;
        ea = model_out(ka, 1, mba);
        eb = model_out(kb, 3, mbb);
        chk_dut("A", ea, a_re, a_addr, a_we, a_wv, a_row, a_mode, a_busy, a_done);
        chk_dut("B", eb, b_re, b_addr, b_we, b_wv, b_row, b_mode, b_busy, b_done);
        if (ea.wv) chk("A.tap2", tap[2], rowdata(mba + 16'(ea.row)));
    endtask

    vec_t tbl [11];

    initial begin
        for (int i = 0; i < 10; i++) tap[i] = 32'h0;
        // Nominal pass; record i = inputs in cycle i, DUT A outputs in cycle i+1.
        tbl[0]  = '{1'b1, 16'h0100, mk(1, 16'h100, 0, 0, 0, 1, 1, 0)};
        tbl[1]  = '{1'b0, 16'h0000, mk(1, 16'h101, 1, 0, 0, 1, 1, 0)};
        tbl[2]  = '{1'b0, 16'h0000, mk(1, 16'h102, 1, 0, 0, 1, 1, 0)};
        tbl[3]  = '{1'b0, 16'h0000, mk(1, 16'h103, 1, 0, 0, 1, 1, 0)};
        tbl[4]  = '{1'b0, 16'h0000, mk(0, 16'h000, 1, 1, 0, 1, 1, 0)};
        tbl[5]  = '{1'b0, 16'h0000, mk(0, 16'h000, 0, 1, 1, 1, 1, 0)};
        tbl[6]  = '{1'b0, 16'h0000, mk(0, 16'h000, 0, 1, 2, 1, 1, 0)};
        tbl[7]  = '{1'b0, 16'h0000, mk(0, 16'h000, 0, 1, 3, 1, 1, 0)};
        tbl[8]  = '{1'b0, 16'h0000, mk(0, 16'h000, 0, 0, 0, 0, 1, 1)};
        tbl[9]  = '{1'b0, 16'h0000, mk(0, 16'h000, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1'b0, 16'h0000, mk(0, 16'h000, 0, 0, 0, 0, 0, 0)};

        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            start = tbl[i].st;
            base_addr = tbl[i].base;
            step();
            chk_dut("T", tbl[i].e, a_re, a_addr, a_we, a_wv, a_row, a_mode, a_busy, a_done);
        end
        chk("A.tap2_cleared", tap[2], 32'h0);

        // Abort at cycle 3 of a pass.
        start = 1'b1; base_addr = 16'h0200; step();
        start = 1'b0; step(); step();
        abort = 1'b1; step();
        abort = 1'b0;
        chk("abort.idle", {29'h0, a_busy, a_wv, a_done}, 32'h0);
        repeat (10) step();

        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0; step();
        chk("start_abort.busy", 32'(a_busy), 32'h0);

        // Reset mid-pass, then a clean pass.
        start = 1'b1; base_addr = 16'h0300; step();
        start = 1'b0; repeat (5) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        chk("reset.outs", {a_re, a_addr, a_we, a_wv, a_row, a_mode, a_busy, a_done}, 32'h0);
        start = 1'b1; base_addr = 16'h0400; step();
        start = 1'b0; repeat (14) step();

        // start held high across passes; base near the top exercises address wrap.
        start = 1'b1; base_addr = 16'hFFFE;
        repeat (30) step();
        start = 1'b0; repeat (15) step();

        // start pulses while busy.
        start = 1'b1; base_addr = 16'h0500; step();
        for (int i = 0; i < 12; i++) begin
            start = i[0];
            base_addr = 16'($urandom);
            step();
        end
        start = 1'b0; repeat (15) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 39) == 0);
            base_addr = 16'($urandom);
            step();
        end
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (20) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
